// File: rtl/sixteen_way_demux_put_blk_pipe4_pkg.sv
`default_nettype none
// ============================================================================
// Module : sixteen_way_demux_put_blk_pipe4_pkg
// Brief  : Shared widths and types for the 16-lane put-block demux tree.
// Rev    : 1.0  initial release
// ============================================================================
package sixteen_way_demux_put_blk_pipe4_pkg;

    localparam int SUB_BLK_BIT = 32;
    localparam int SFT_BIT     = 4;
    localparam int LANE_NUM    = 16;
    localparam int NODE_NUM    = 2 * LANE_NUM - 1;

    typedef logic [SUB_BLK_BIT-1:0] sub_blk_t;
    typedef logic [SFT_BIT-1:0]     lane_sel_t;

    // Tree depth of a heap-indexed node (root = 1).
    function automatic int node_level(input int idx);
        int lvl;
        lvl = 0;
        for (int v = idx; v > 1; v = v / 2) begin
            lvl = lvl + 1;
        end
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sixteen_way_demux_put_blk_pipe4_if.sv
`default_nettype none
// ============================================================================
// Module : sixteen_way_demux_put_blk_pipe4_if
// Brief  : Put-side bus between the ping-pong shifter and the lane stores.
// Rev    : 1.0  initial release
// ============================================================================
interface sixteen_way_demux_put_blk_pipe4_if #(
    parameter int CNT_BIT = 16
);
    import sixteen_way_demux_put_blk_pipe4_pkg::*;

    logic                          puti;
    lane_sel_t                     sel;
    sub_blk_t                      subBlki;
    logic                          needPang;
    logic                          myTurnPingPong;
    lane_sel_t                     needPangStartInc;
    lane_sel_t                     needPangEndInc;
    logic [LANE_NUM*SUB_BLK_BIT-1:0] subBlko;
    logic [LANE_NUM-1:0]           putBlko;
    logic [CNT_BIT-1:0]            dropCnt;

    modport master (
        output puti, sel, subBlki, needPang, myTurnPingPong,
               needPangStartInc, needPangEndInc,
        input  subBlko, putBlko, dropCnt
    );

    modport slave (
        input  puti, sel, subBlki, needPang, myTurnPingPong,
               needPangStartInc, needPangEndInc,
        output subBlko, putBlko, dropCnt
    );

endinterface
`default_nettype wire

// File: rtl/sixteen_way_demux_put_blk_pipe4_one_to_two_demux_reg.sv
`default_nettype none
// ============================================================================
// Module : one_to_two_demux_reg
// Brief  : Registered 1:2 demux node; loads only the selected side.
// Rev    : 1.0  initial release
// ============================================================================
module one_to_two_demux_reg #(
    parameter int SUB_BLK_BIT = 32
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   sel,
    input  wire logic                   vldi,
    input  wire logic [SUB_BLK_BIT-1:0] subBlki,
    output logic                        vldo0,
    output logic                        vldo1,
    output logic [SUB_BLK_BIT-1:0]      subBlko0,
    output logic [SUB_BLK_BIT-1:0]      subBlko1
);

    logic                   vldo0_d,    vldo0_q;
    logic                   vldo1_d,    vldo1_q;
    logic [SUB_BLK_BIT-1:0] subBlko0_d, subBlko0_q;
    logic [SUB_BLK_BIT-1:0] subBlko1_d, subBlko1_q;

    // Data is gated by the valid so an idle slot never overwrites a lane
    // with stale upstream contents.
    always_comb begin
        vldo0_d    = vldi & ~sel;
        vldo1_d    = vldi &  sel;
        subBlko0_d = subBlko0_q;
        subBlko1_d = subBlko1_q;
        if (vldi && !sel) begin
            subBlko0_d = subBlki;
        end
        if (vldi && sel) begin
            subBlko1_d = subBlki;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vldo0_q    <= 1'b0;
            vldo1_q    <= 1'b0;
            subBlko0_q <= '0;
            subBlko1_q <= '0;
        end else begin
            vldo0_q    <= vldo0_d;
            vldo1_q    <= vldo1_d;
            subBlko0_q <= subBlko0_d;
            subBlko1_q <= subBlko1_d;
        end
    end

    assign vldo0    = vldo0_q;
    assign vldo1    = vldo1_q;
    assign subBlko0 = subBlko0_q;
    assign subBlko1 = subBlko1_q;

endmodule
`default_nettype wire

// File: rtl/sixteen_way_demux_put_blk_pipe4.sv
`default_nettype none
// ============================================================================
// Module : sixteen_way_demux_put_blk_pipe4
// Brief  : Qualified put routed to one of 16 lane registers, 4-cycle tree.
// Rev    : 1.0  initial release
// ============================================================================
module sixteen_way_demux_put_blk_pipe4 #(
    parameter int CNT_BIT = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    sixteen_way_demux_put_blk_pipe4_if.slave bus
);
    import sixteen_way_demux_put_blk_pipe4_pkg::*;

    logic               in_window_w;
    logic               put_w;
    logic               drop_w;
    logic [CNT_BIT-1:0] dropCnt_d,  dropCnt_q;
    logic [2:0]         sel_p1_d,   sel_p1_q;
    logic [1:0]         sel_p2_d,   sel_p2_q;
    logic               sel_p3_d,   sel_p3_q;
    logic [3:0]         lvl_sel_w;

    // Heap-indexed tree: node i feeds 2i / 2i+1; lanes are nodes 16..31.
    logic     vld_n  [1:NODE_NUM];
    sub_blk_t data_n [1:NODE_NUM];

    // An inverted window (start > end) can never match, so it is empty.
    always_comb begin
        in_window_w = (bus.sel >= bus.needPangStartInc) &&
                      (bus.sel <= bus.needPangEndInc);
        put_w       = bus.puti && bus.myTurnPingPong &&
                      (bus.needPang || !in_window_w);
        drop_w      = bus.puti && !put_w;
        dropCnt_d   = dropCnt_q;
        if (drop_w && (dropCnt_q != {CNT_BIT{1'b1}})) begin
            dropCnt_d = dropCnt_q + 1'b1;
        end
        sel_p1_d    = bus.sel[2:0];
        sel_p2_d    = sel_p1_q[1:0];
        sel_p3_d    = sel_p2_q[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dropCnt_q <= '0;
            sel_p1_q  <= '0;
            sel_p2_q  <= '0;
            sel_p3_q  <= 1'b0;
        end else begin
            dropCnt_q <= dropCnt_d;
            sel_p1_q  <= sel_p1_d;
            sel_p2_q  <= sel_p2_d;
            sel_p3_q  <= sel_p3_d;
        end
    end

    // Select bit consumed at each tree level, aligned with the data there.
    assign lvl_sel_w = {sel_p3_q, sel_p2_q[1], sel_p1_q[2], bus.sel[3]};

    assign vld_n[1]  = put_w;
    assign data_n[1] = bus.subBlki;

    generate
        for (genvar i = 1; i < LANE_NUM; i++) begin : g_node
            localparam int LVL = node_level(i);
            one_to_two_demux_reg #(
                .SUB_BLK_BIT (SUB_BLK_BIT)
            ) u_node (
                .clk      (clk),
                .reset    (reset),
                .sel      (lvl_sel_w[LVL]),
                .vldi     (vld_n[i]),
                .subBlki  (data_n[i]),
                .vldo0    (vld_n[2*i]),
                .vldo1    (vld_n[2*i+1]),
                .subBlko0 (data_n[2*i]),
                .subBlko1 (data_n[2*i+1])
            );
        end

        for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
            assign bus.subBlko[k*SUB_BLK_BIT +: SUB_BLK_BIT] = data_n[LANE_NUM+k];
            assign bus.putBlko[k]                            = vld_n[LANE_NUM+k];
        end
    endgenerate

    assign bus.dropCnt = dropCnt_q;

endmodule
`default_nettype wire
